// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bit-serial bus scheduler: FSM state encoding,
// slave-select codes, master/slave counts and the select-to-one-hot helper.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int NUM_SLAVES  = 3;

    // Scheduler states; the numeric values are exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_WAIT_SLAVE = 3'd3,
        ST_TRANSFER   = 3'd4,
        ST_ERROR      = 3'd5,
        ST_RELEASE    = 3'd6
    } state_t;

    // Two leading serial address bits select the target slave.
    localparam logic [1:0] SEL_S1  = 2'b00;
    localparam logic [1:0] SEL_S2  = 2'b01;
    localparam logic [1:0] SEL_S3  = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    // Map a select code to the one-hot slave vector; the illegal code maps to
    // no slave at all so it can never steer the slave-side mux.
    function automatic logic [NUM_SLAVES-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_SLAVES-1:0] oh;
        case (sel)
            SEL_S1:  oh = 3'b001;
            SEL_S2:  oh = 3'b010;
            SEL_S3:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational two-requester round-robin picker. When both requesters are
// active the one that was not served last wins; a lone requester always wins.
// Ports:
//   req         in  2  request vector, bit0 = m1, bit1 = m2
//   last_served in  1  index of the master served last (0 = m1, 1 = m2)
//   pick        out 2  one-hot winner, zero when nobody requests
// -----------------------------------------------------------------------------
module rr_picker
    import bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_served,
    output logic [NUM_MASTERS-1:0] pick
);

    // Winner selection with fairness only on a tie.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_served ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_scheduler.sv
// -----------------------------------------------------------------------------
// bus_scheduler
// Cycle-level scheduler for a bit-serial bus shared by two masters and three
// slaves. Arbitrates round-robin, decodes the two leading serial address bits
// as a slave select, waits for the slave to be ready, then steers the bus
// multiplexers until the granted master drops its request. Slave timeouts and
// illegal selects raise a one-cycle bus_error pulse.
// Ports:
//   clk          in  1  system clock, rising edge
//   reset        in  1  asynchronous active-low reset
//   m_request    in  2  bus request per master (bit0 = m1)
//   m_addr       in  2  serial address bit per master
//   m_addr_valid in  2  serial address bit valid per master
//   s_ready      in  3  slave ready per slave (bit0 = s1)
//   s_valid_out  in  3  slave response bit valid per slave
//   grant        out 2  one-hot granted master (master-side mux)
//   m_available  out 2  bus-ready to each master, shifting allowed while high
//   slave_sel    out 3  one-hot routed slave (slave-side mux), TRANSFER only
//   bus_error    out 1  one-cycle error pulse
//   state        out 3  current FSM state for debug
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned SEL_BITS = 2
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic [NUM_MASTERS-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0] m_addr_valid,
    input  logic [NUM_SLAVES-1:0]  s_ready,
    input  logic [NUM_SLAVES-1:0]  s_valid_out,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [NUM_MASTERS-1:0] m_available,
    output logic [NUM_SLAVES-1:0]  slave_sel,
    output logic                   bus_error,
    output logic [2:0]             state
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t                 state_r, state_s;
    logic                   owner_r, owner_s;          // granted master index
    logic                   last_served_r, last_served_s;
    logic [SEL_BITS-1:0]    sel_r, sel_s;              // select shift register
    logic                   bit_seen_r, bit_seen_s;    // first select bit taken
    logic [7:0]             cnt_r, cnt_s;              // no-progress counter

    logic [NUM_MASTERS-1:0] grant_r, grant_s;
    logic [NUM_MASTERS-1:0] avail_r, avail_s;
    logic [NUM_SLAVES-1:0]  slave_sel_r, slave_sel_s;
    logic                   bus_error_r, bus_error_s;

    logic [NUM_MASTERS-1:0] pick_s;
    logic                   req_g_s, addr_g_s, valid_g_s;
    logic [NUM_SLAVES-1:0]  target_oh_s;
    logic                   ready_t_s, vout_t_s;
    logic [7:0]             cnt_inc_s;
    logic [NUM_MASTERS-1:0] owner_oh_s;

    rr_picker u_rr_picker (
        .req         (m_request),
        .last_served (last_served_r),
        .pick        (pick_s)
    );

    // Only the granted master and the decoded slave can influence the FSM.
    assign req_g_s     = m_request[owner_r];
    assign addr_g_s    = m_addr[owner_r];
    assign valid_g_s   = m_addr_valid[owner_r];
    assign target_oh_s = sel_onehot(sel_r);
    assign ready_t_s   = |(s_ready & target_oh_s);
    assign vout_t_s    = |(s_valid_out & target_oh_s);
    // Saturating increment so the counter parks at the limit instead of wrapping.
    assign cnt_inc_s   = (cnt_r == TO_LIM) ? cnt_r : cnt_r + 8'd1;

    // Next-state, ownership, select shifter and timeout counter.
    always_comb begin
        state_s       = state_r;
        owner_s       = owner_r;
        last_served_s = last_served_r;
        sel_s         = sel_r;
        bit_seen_s    = bit_seen_r;
        cnt_s         = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s      = 8'd0;
                sel_s      = {SEL_BITS{1'b0}};
                bit_seen_s = 1'b0;
                if (|m_request) begin
                    state_s = ST_GRANT;
                    owner_s = (pick_s == 2'b10);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req_g_s) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!req_g_s) begin
                    state_s = ST_RELEASE;
                end else if (valid_g_s) begin
                    // MSB-first: the first bit ends up in the upper position.
                    sel_s = {sel_r[SEL_BITS-2:0], addr_g_s};
                    if (bit_seen_r) begin
                        bit_seen_s = 1'b0;
                        if (sel_s == SEL_BAD) begin
                            state_s = ST_ERROR;
                        end else begin
                            state_s = ST_WAIT_SLAVE;
                        end
                    end else begin
                        bit_seen_s = 1'b1;
                    end
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_WAIT_SLAVE: begin
                if (!req_g_s) begin
                    state_s = ST_RELEASE;
                end else if (ready_t_s) begin
                    state_s = ST_TRANSFER;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == TO_LIM) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_WAIT_SLAVE;
                    end
                end
            end
            ST_TRANSFER: begin
                if (!req_g_s) begin
                    state_s = ST_RELEASE;
                end else if (valid_g_s || vout_t_s) begin
                    cnt_s = 8'd0;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == TO_LIM) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_TRANSFER;
                    end
                end
            end
            ST_ERROR: begin
                cnt_s   = 8'd0;
                state_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                cnt_s         = 8'd0;
                last_served_s = owner_r;
                state_s       = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the state being entered so that they
    // register in lock-step with it. The owner register keeps the master
    // identity through ERROR/RELEASE, but the grant output is already low there.
    always_comb begin
        grant_s     = 2'b00;
        avail_s     = 2'b00;
        slave_sel_s = 3'b000;
        bus_error_s = 1'b0;
        owner_oh_s  = owner_s ? 2'b10 : 2'b01;
        case (state_s)
            ST_GRANT: begin
                grant_s = owner_oh_s;
            end
            ST_DECODE: begin
                grant_s = owner_oh_s;
                avail_s = owner_oh_s;
            end
            ST_WAIT_SLAVE: begin
                grant_s = owner_oh_s;
            end
            ST_TRANSFER: begin
                grant_s     = owner_oh_s;
                avail_s     = owner_oh_s;
                slave_sel_s = sel_onehot(sel_s);
            end
            ST_ERROR: begin
                bus_error_s = 1'b1;
            end
            default: begin
                grant_s = 2'b00;
            end
        endcase
    end

    // State and datapath registers; last_served resets to m2 so m1 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
            sel_r         <= {SEL_BITS{1'b0}};
            bit_seen_r    <= 1'b0;
            cnt_r         <= 8'd0;
        end else begin
            state_r       <= state_s;
            owner_r       <= owner_s;
            last_served_r <= last_served_s;
            sel_r         <= sel_s;
            bit_seen_r    <= bit_seen_s;
            cnt_r         <= cnt_s;
        end
    end

    // Output registers; cleared asynchronously so the muxes open at once on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r     <= 2'b00;
            avail_r     <= 2'b00;
            slave_sel_r <= 3'b000;
            bus_error_r <= 1'b0;
        end else begin
            grant_r     <= grant_s;
            avail_r     <= avail_s;
            slave_sel_r <= slave_sel_s;
            bus_error_r <= bus_error_s;
        end
    end

    assign grant       = grant_r;
    assign m_available = avail_r;
    assign slave_sel   = slave_sel_r;
    assign bus_error   = bus_error_r;
    assign state       = state_r;

endmodule
